// File: rtl/mult_pkg.sv
// ---------------------------------------------------------------------------
// mult_pkg
//   Shared sizing helpers for the pipelined multiplier.
//   - ceil_div       : integer ceiling division
//   - min_int        : integer minimum, used to clip the last row range
//   - prod_width     : full product width (WA + WB)
//   - rows_per_stage : partial-product rows handled per pipeline stage
//   - payload_width  : packed width of the per-stage payload
//                      {sum, a_ext, b_rem, tc}
// ---------------------------------------------------------------------------
package mult_pkg;

  localparam int OPERAND_W_MIN = 2;
  localparam int OPERAND_W_MAX = 32;

  function automatic int ceil_div(input int n, input int d);
    return (n + d - 1) / d;
  endfunction

  function automatic int min_int(input int x, input int y);
    return (x < y) ? x : y;
  endfunction

  function automatic int prod_width(input int wa, input int wb);
    return wa + wb;
  endfunction

  function automatic int rows_per_stage(input int wb, input int stages);
    return ceil_div(wb, stages);
  endfunction

  // sum and a_ext are product-wide, b_rem carries the multiplier, plus tc.
  function automatic int payload_width(input int wa, input int wb);
    return 2 * prod_width(wa, wb) + wb + 1;
  endfunction

endpackage

// File: rtl/mult_pipe_if.sv
// ---------------------------------------------------------------------------
// mult_pipe_if
//   Operand and result handshakes of the pipelined multiplier.
//   Producer side : in_valid, in_ready, in_a[WA], in_b[WB], in_tc
//   Consumer side : out_valid, out_ready, out_p[WA+WB], out_tc
//   modport master : the environment (drives operands, accepts results)
//   modport slave  : the multiplier itself
// ---------------------------------------------------------------------------
interface mult_pipe_if #(
  parameter int WA = 8,
  parameter int WB = 8
);

  logic              in_valid;
  logic              in_ready;
  logic [WA-1:0]     in_a;
  logic [WB-1:0]     in_b;
  logic              in_tc;
  logic              out_valid;
  logic              out_ready;
  logic [WA+WB-1:0]  out_p;
  logic              out_tc;

  modport master (
    output in_valid, in_a, in_b, in_tc, out_ready,
    input  in_ready, out_valid, out_p, out_tc
  );

  modport slave (
    input  in_valid, in_a, in_b, in_tc, out_ready,
    output in_ready, out_valid, out_p, out_tc
  );

endinterface

// File: rtl/mult_pp_stage.sv
// ---------------------------------------------------------------------------
// mult_pp_stage
//   One register stage of the pipelined multiplier. Adds partial-product
//   rows ROW_LO..ROW_HI of a*b into the running sum and registers the
//   result together with the operands and the signed-mode flag.
//   Ports:
//     clock, reset_n : clock, synchronous active-low reset
//     valid_i/ready_o: upstream handshake (ready_o = !v || ready_i)
//     ready_i        : downstream stage (or consumer) ready
//     pl_i           : incoming payload {sum, a_ext, b_rem, tc}
//     v_o, pl_o      : registered valid bit and payload
// ---------------------------------------------------------------------------
module mult_pp_stage
  import mult_pkg::*;
#(
  parameter int WA     = 8,
  parameter int WB     = 8,
  parameter int ROW_LO = 0,
  parameter int ROW_HI = 1
) (
  input  logic                                clock,
  input  logic                                reset_n,
  input  logic                                valid_i,
  output logic                                ready_o,
  input  logic                                ready_i,
  input  logic [payload_width(WA, WB)-1:0]    pl_i,
  output logic                                v_o,
  output logic [payload_width(WA, WB)-1:0]    pl_o
);

  localparam int PW = prod_width(WA, WB);

  typedef struct packed {
    logic [PW-1:0] sum;
    logic [PW-1:0] a_ext;
    logic [WB-1:0] b_rem;
    logic          tc;
  } payload_t;

  payload_t pl_in;
  payload_t pl_d;
  payload_t pl_q;
  logic     v_q;

  assign pl_in = pl_i;

  // Row r has weight 2^r; in signed mode the top multiplier bit has
  // weight -2^(WB-1), so that row is subtracted instead of added.
  always_comb begin
    pl_d = pl_in;
    for (int r = 0; r < WB; r++) begin
      if (r >= ROW_LO && r <= ROW_HI && pl_in.b_rem[r]) begin
        if (pl_in.tc && r == WB - 1) begin
          pl_d.sum = pl_d.sum - (pl_in.a_ext << r);
        end else begin
          pl_d.sum = pl_d.sum + (pl_in.a_ext << r);
        end
      end
    end
  end

  // A stage can take a new beat when empty or when its own beat leaves.
  assign ready_o = !v_q || ready_i;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      v_q  <= 1'b0;
      pl_q <= '0;
    end else if (ready_o) begin
      v_q <= valid_i;
      if (valid_i) begin
        pl_q <= pl_d;
      end
    end
  end

  assign v_o  = v_q;
  assign pl_o = pl_q;

endmodule

// File: rtl/mult_pipe.sv
// ---------------------------------------------------------------------------
// mult_pipe
//   Pipelined WA x WB integer multiplier, unsigned or two's complement per
//   beat, with valid/ready on both sides and per-stage back-pressure so
//   bubbles collapse.
//   Ports:
//     clock   : sole clock, rising edge
//     reset_n : synchronous active-low reset
//     bus     : mult_pipe_if.slave (operand and result handshakes)
//   Parameters: WA, WB (2..32), STAGES (1..WB register stages).
// ---------------------------------------------------------------------------
module mult_pipe
  import mult_pkg::*;
#(
  parameter int WA     = 8,
  parameter int WB     = 8,
  parameter int STAGES = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  mult_pipe_if.slave  bus
);

  localparam int PW  = prod_width(WA, WB);
  localparam int R   = rows_per_stage(WB, STAGES);
  localparam int PLW = payload_width(WA, WB);

  typedef struct packed {
    logic [PW-1:0] sum;
    logic [PW-1:0] a_ext;
    logic [WB-1:0] b_rem;
    logic          tc;
  } payload_t;

  // Index s is the input of stage s; index STAGES is the pipe output.
  logic [STAGES:0] valid_c;
  logic [STAGES:0] ready_c;
  logic [PLW-1:0]  pl_c [STAGES+1];

  payload_t pl_first;
  payload_t pl_last;
  logic     unused_payload;

  // Sign extension of a only applies in signed mode.
  always_comb begin
    pl_first       = '0;
    pl_first.a_ext = {{(PW-WA){bus.in_tc & bus.in_a[WA-1]}}, bus.in_a};
    pl_first.b_rem = bus.in_b;
    pl_first.tc    = bus.in_tc;
  end

  assign valid_c[0]      = bus.in_valid;
  assign pl_c[0]         = pl_first;
  assign ready_c[STAGES] = bus.out_ready;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      mult_pp_stage #(
        .WA     (WA),
        .WB     (WB),
        .ROW_LO (gi * R),
        .ROW_HI (min_int(WB, (gi + 1) * R) - 1)
      ) u_stage (
        .clock   (clock),
        .reset_n (reset_n),
        .valid_i (valid_c[gi]),
        .ready_o (ready_c[gi]),
        .ready_i (ready_c[gi+1]),
        .pl_i    (pl_c[gi]),
        .v_o     (valid_c[gi+1]),
        .pl_o    (pl_c[gi+1])
      );
    end
  endgenerate

  // The stages ignore in_valid while in reset, but the producer must
  // not see a ready it could mistake for an accepted beat.
  assign bus.in_ready = reset_n & ready_c[0];

  assign pl_last       = pl_c[STAGES];
  assign bus.out_valid = valid_c[STAGES];
  assign bus.out_p     = pl_last.sum;
  assign bus.out_tc    = pl_last.tc;

  // Operands are fully consumed by the last stage.
  assign unused_payload = ^{pl_last.a_ext, pl_last.b_rem};

endmodule

// File: tb/tb_mult_pipe.sv
// ---------------------------------------------------------------------------
// tb_mult_pipe
//   Three multiplier instances: default 8x8/4 stages, 2x2/1 stage and
//   5x7/3 stages. Inputs change 1 time unit after the rising edge and
//   outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_mult_pipe;

  logic clk;
  logic reset_n;
  int   errors;
  int   checks;

  mult_pipe_if #(.WA(8), .WB(8)) d_if ();
  mult_pipe_if #(.WA(2), .WB(2)) s_if ();
  mult_pipe_if #(.WA(5), .WB(7)) r_if ();

  mult_pipe #(.WA(8), .WB(8), .STAGES(4)) u_def (
    .clock   (clk),
    .reset_n (reset_n),
    .bus     (d_if)
  );

  mult_pipe #(.WA(2), .WB(2), .STAGES(1)) u_small (
    .clock   (clk),
    .reset_n (reset_n),
    .bus     (s_if)
  );

  mult_pipe #(.WA(5), .WB(7), .STAGES(3)) u_rand (
    .clock   (clk),
    .reset_n (reset_n),
    .bus     (r_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] ref_prod(input logic [4:0] a, input logic [6:0] b,
                                           input logic tc);
    int sa;
    int sb;
    int p;
    sa = tc ? {{27{a[4]}}, a} : {27'd0, a};
    sb = tc ? {{25{b[6]}}, b} : {25'd0, b};
    p  = sa * sb;
    return p[11:0];
  endfunction

  task automatic test_reset();
    repeat (2) tick();
    @(negedge clk);
    checks++; if (d_if.out_valid !== 1'b0) begin errors++; $display("FAIL reset_def_valid: got %b want 0", d_if.out_valid); end
    checks++; if (d_if.out_p !== 16'h0) begin errors++; $display("FAIL reset_def_p: got %h want 0000", d_if.out_p); end
    checks++; if (d_if.out_tc !== 1'b0) begin errors++; $display("FAIL reset_def_tc: got %b want 0", d_if.out_tc); end
    checks++; if (d_if.in_ready !== 1'b0) begin errors++; $display("FAIL reset_def_in_ready: got %b want 0", d_if.in_ready); end
    checks++; if (s_if.out_valid !== 1'b0) begin errors++; $display("FAIL reset_small_valid: got %b want 0", s_if.out_valid); end
    checks++; if (s_if.out_p !== 4'h0) begin errors++; $display("FAIL reset_small_p: got %h want 0", s_if.out_p); end
    checks++; if (r_if.out_valid !== 1'b0) begin errors++; $display("FAIL reset_rand_valid: got %b want 0", r_if.out_valid); end
    checks++; if (r_if.out_p !== 12'h0) begin errors++; $display("FAIL reset_rand_p: got %h want 000", r_if.out_p); end
    reset_n = 1'b1;
    #1;
    checks++; if (d_if.in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b want 1", d_if.in_ready); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic        exp_v;
    logic [15:0] exp_p;
    d_if.out_ready = 1'b1;
    d_if.in_tc     = 1'b0;
    d_if.in_valid  = 1'b1;
    d_if.in_a      = 8'd255;
    d_if.in_b      = 8'd255;
    @(negedge clk);
    checks++; if (d_if.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready0: got %b want 1", d_if.in_ready); end
    tick();
    d_if.in_a = 8'd3;
    d_if.in_b = 8'd3;
    @(negedge clk);
    checks++; if (d_if.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready1: got %b want 1", d_if.in_ready); end
    tick();
    d_if.in_valid = 1'b0;
    // k counts edges after the first acceptance edge.
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      exp_v = (k == 3) || (k == 4);
      exp_p = (k == 3) ? 16'd65025 : 16'd9;
      checks++; if (d_if.out_valid !== exp_v) begin errors++; $display("FAIL b2b_valid_k%0d: got %b want %b", k, d_if.out_valid, exp_v); end
      if (exp_v) begin
        checks++; if (d_if.out_p !== exp_p) begin errors++; $display("FAIL b2b_p_k%0d: got %0d want %0d", k, d_if.out_p, exp_p); end
        $display("xfer b2b k=%0d p=%0d", k, d_if.out_p);
      end
      checks++; if (d_if.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready_k%0d: got %b want 1", k, d_if.in_ready); end
      tick();
    end
  endtask

  task automatic test_signed();
    logic [15:0] got_p [2];
    logic        got_tc [2];
    int          n;
    n = 0;
    d_if.out_ready = 1'b1;
    d_if.in_valid  = 1'b1;
    d_if.in_tc     = 1'b1;
    d_if.in_a      = 8'h80;
    d_if.in_b      = 8'h7F;
    @(negedge clk);
    checks++; if (d_if.in_ready !== 1'b1) begin errors++; $display("FAIL signed_ready: got %b want 1", d_if.in_ready); end
    tick();
    d_if.in_a = 8'hFF;
    d_if.in_b = 8'hFF;
    tick();
    d_if.in_valid = 1'b0;
    d_if.in_tc    = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (d_if.out_valid && n < 2) begin
        got_p[n]  = d_if.out_p;
        got_tc[n] = d_if.out_tc;
        $display("xfer signed p=%h tc=%b", d_if.out_p, d_if.out_tc);
        n++;
      end
      tick();
    end
    checks++; if (n !== 2) begin errors++; $display("FAIL signed_count: got %0d want 2", n); end
    if (n == 2) begin
      checks++; if (got_p[0] !== 16'hC080) begin errors++; $display("FAIL signed_p0: got %h want c080", got_p[0]); end
      checks++; if (got_tc[0] !== 1'b1) begin errors++; $display("FAIL signed_tc0: got %b want 1", got_tc[0]); end
      checks++; if (got_p[1] !== 16'h0001) begin errors++; $display("FAIL signed_p1: got %h want 0001", got_p[1]); end
      checks++; if (got_tc[1] !== 1'b1) begin errors++; $display("FAIL signed_tc1: got %b want 1", got_tc[1]); end
    end
  endtask

  task automatic test_small_sweep();
    logic [3:0] exp_p;
    s_if.out_ready = 1'b1;
    s_if.in_tc     = 1'b0;
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        s_if.in_valid = 1'b1;
        s_if.in_a     = 2'(a);
        s_if.in_b     = 2'(b);
        exp_p         = 4'(a * b);
        #1;
        checks++; if (s_if.in_ready !== 1'b1) begin errors++; $display("FAIL sweep_ready_%0dx%0d: got %b want 1", a, b, s_if.in_ready); end
        tick();
        @(negedge clk);
        checks++; if (s_if.out_valid !== 1'b1) begin errors++; $display("FAIL sweep_valid_%0dx%0d: got %b want 1", a, b, s_if.out_valid); end
        checks++; if (s_if.out_p !== exp_p) begin errors++; $display("FAIL sweep_p_%0dx%0d: got %0d want %0d", a, b, s_if.out_p, exp_p); end
        $display("xfer sweep %0dx%0d p=%0d", a, b, s_if.out_p);
      end
    end
    s_if.in_valid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    logic [7:0]  ba [6];
    logic [7:0]  bb [6];
    logic [15:0] bp [6];
    int          idx;
    int          got;
    int          guard;
    logic        fire_in;
    logic        fire_out;
    ba  = '{8'd1, 8'd10, 8'd100, 8'd255, 8'd7, 8'd200};
    bb  = '{8'd2, 8'd20, 8'd3, 8'd2, 8'd9, 8'd200};
    bp  = '{16'd2, 16'd200, 16'd300, 16'd510, 16'd63, 16'd40000};
    idx = 0;
    got = 0;
    d_if.out_ready = 1'b0;
    d_if.in_tc     = 1'b0;
    d_if.in_valid  = 1'b1;
    d_if.in_a      = ba[0];
    d_if.in_b      = bb[0];
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clk);
      fire_in = d_if.in_valid && d_if.in_ready;
      if (cyc >= 4) begin
        checks++;
        if (d_if.out_valid !== 1'b1 || d_if.out_p !== bp[0]) begin
          errors++; $display("FAIL stall_hold_c%0d: got v=%b p=%0d want v=1 p=%0d", cyc, d_if.out_valid, d_if.out_p, bp[0]);
        end
      end
      tick();
      if (fire_in) begin
        idx++;
        if (idx < 6) begin d_if.in_a = ba[idx]; d_if.in_b = bb[idx]; end
        else d_if.in_valid = 1'b0;
      end
    end
    @(negedge clk);
    checks++; if (idx !== 4) begin errors++; $display("FAIL stall_accepted: got %0d want 4", idx); end
    checks++; if (d_if.in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready: got %b want 0", d_if.in_ready); end
    checks++; if (d_if.out_p !== bp[0]) begin errors++; $display("FAIL stall_p: got %0d want %0d", d_if.out_p, bp[0]); end
    d_if.out_ready = 1'b1;
    #1;
    guard = 0;
    while (got < 6 && guard < 40) begin
      fire_in  = d_if.in_valid && d_if.in_ready;
      fire_out = d_if.out_valid && d_if.out_ready;
      if (fire_out) begin
        checks++; if (d_if.out_p !== bp[got]) begin errors++; $display("FAIL drain_p%0d: got %0d want %0d", got, d_if.out_p, bp[got]); end
        $display("xfer drain %0d p=%0d", got, d_if.out_p);
        got++;
      end
      tick();
      if (fire_in) begin
        idx++;
        if (idx < 6) begin d_if.in_a = ba[idx]; d_if.in_b = bb[idx]; end
        else d_if.in_valid = 1'b0;
      end
      @(negedge clk);
      guard++;
    end
    checks++; if (got !== 6) begin errors++; $display("FAIL drain_count: got %0d want 6", got); end
    checks++; if (idx !== 6) begin errors++; $display("FAIL drain_accepted: got %0d want 6", idx); end
    d_if.in_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    int n;
    n = 0;
    d_if.out_ready = 1'b0;
    d_if.in_tc     = 1'b0;
    for (int i = 0; i < 3; i++) begin
      d_if.in_valid = 1'b1;
      d_if.in_a     = 8'(11 + i);
      d_if.in_b     = 8'd2;
      @(negedge clk);
      checks++; if (d_if.in_ready !== 1'b1) begin errors++; $display("FAIL rmid_fill_%0d: got %b want 1", i, d_if.in_ready); end
      tick();
    end
    reset_n       = 1'b0;
    d_if.in_valid = 1'b1;
    d_if.in_a     = 8'd5;
    d_if.in_b     = 8'd6;
    @(negedge clk);
    checks++; if (d_if.in_ready !== 1'b0) begin errors++; $display("FAIL rmid_ready_in_reset: got %b want 0", d_if.in_ready); end
    tick();
    reset_n = 1'b1;
    @(negedge clk);
    checks++; if (d_if.out_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b want 0", d_if.out_valid); end
    checks++; if (d_if.out_p !== 16'h0) begin errors++; $display("FAIL rmid_p: got %h want 0000", d_if.out_p); end
    checks++; if (d_if.out_tc !== 1'b0) begin errors++; $display("FAIL rmid_tc: got %b want 0", d_if.out_tc); end
    checks++; if (d_if.in_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready_after: got %b want 1", d_if.in_ready); end
    tick();
    d_if.in_valid  = 1'b0;
    d_if.out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (d_if.out_valid && d_if.out_ready) begin
        n++;
        checks++; if (d_if.out_p !== 16'd30) begin errors++; $display("FAIL rmid_out: got %0d want 30", d_if.out_p); end
        $display("xfer rmid p=%0d", d_if.out_p);
      end
      tick();
    end
    checks++; if (n !== 1) begin errors++; $display("FAIL rmid_count: got %0d want 1", n); end
  endtask

  task automatic test_random();
    logic [12:0] sb [$];
    logic [12:0] exp_e;
    logic        fire_in;
    logic        fire_out;
    logic        prev_stall;
    logic [11:0] prev_p;
    logic        prev_tc;
    int          n_out;
    prev_stall     = 1'b0;
    prev_p         = '0;
    prev_tc        = 1'b0;
    n_out          = 0;
    r_if.in_valid  = 1'b0;
    r_if.out_ready = 1'b0;
    for (int cyc = 0; cyc < 10040; cyc++) begin
      @(negedge clk);
      fire_in  = r_if.in_valid && r_if.in_ready;
      fire_out = r_if.out_valid && r_if.out_ready;
      if (prev_stall) begin
        checks++;
        if (r_if.out_valid !== 1'b1 || r_if.out_p !== prev_p || r_if.out_tc !== prev_tc) begin
          errors++; $display("FAIL rand_hold_c%0d: got v=%b p=%h tc=%b want v=1 p=%h tc=%b", cyc, r_if.out_valid, r_if.out_p, r_if.out_tc, prev_p, prev_tc);
        end
      end
      if (fire_in) sb.push_back({r_if.in_tc, ref_prod(r_if.in_a, r_if.in_b, r_if.in_tc)});
      if (fire_out) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL rand_extra_c%0d: got p=%h with no beat pending", cyc, r_if.out_p);
        end else begin
          exp_e = sb.pop_front();
          if ({r_if.out_tc, r_if.out_p} !== exp_e) begin
            errors++; $display("FAIL rand_result_c%0d: got tc=%b p=%h want tc=%b p=%h", cyc, r_if.out_tc, r_if.out_p, exp_e[12], exp_e[11:0]);
          end
        end
        n_out++;
      end
      prev_stall = r_if.out_valid && !r_if.out_ready;
      prev_p     = r_if.out_p;
      prev_tc    = r_if.out_tc;
      tick();
      // A pending beat is held until it is accepted.
      if (fire_in || !r_if.in_valid) begin
        r_if.in_valid = (cyc < 10000) ? ($urandom_range(0, 3) != 0) : 1'b0;
        r_if.in_a     = 5'($urandom);
        r_if.in_b     = 7'($urandom);
        r_if.in_tc    = 1'($urandom);
      end
      r_if.out_ready = (cyc < 10000) ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL rand_pending: got %0d beats left want 0", sb.size()); end
    checks++; if (n_out < 1000) begin errors++; $display("FAIL rand_throughput: got %0d results want at least 1000", n_out); end
    $display("xfer random results=%0d", n_out);
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    reset_n = 1'b0;
    d_if.in_valid = 1'b0; d_if.in_a = '0; d_if.in_b = '0; d_if.in_tc = 1'b0; d_if.out_ready = 1'b0;
    s_if.in_valid = 1'b0; s_if.in_a = '0; s_if.in_b = '0; s_if.in_tc = 1'b0; s_if.out_ready = 1'b0;
    r_if.in_valid = 1'b0; r_if.in_a = '0; r_if.in_b = '0; r_if.in_tc = 1'b0; r_if.out_ready = 1'b0;
    test_reset();
    test_back_to_back();
    test_signed();
    test_small_sweep();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
